// File: rtl/stage_m.sv
// stage_m: memory-access stage of the yari-core pipeline.
// Loads/stores become single-outstanding bus transactions; other ops pass through.
module stage_m #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x_valid,
    input  logic [31:0]       x_pc,
    input  logic [31:0]       x_instr,
    input  logic [5:0]        x_opcode,
    input  logic [31:0]       x_op1_val,
    input  logic [31:0]       x_rt_val,
    input  logic [5:0]        x_wbr,
    input  logic [31:0]       x_res,
    output logic              m_stall,
    output logic              m_valid,
    output logic [31:0]       m_pc,
    output logic [5:0]        m_wbr,
    output logic [31:0]       m_res,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic [31:0]       dmem_wrdata,
    output logic [3:0]        dmem_byteena,
    input  logic              dmem_waitrequest,
    input  logic [31:0]       dmem_readdata,
    input  logic              dmem_readdatavalid
);

    typedef enum logic [1:0] {IDLE, REQ, RDWAIT} state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] ea;
    logic [31:0] ea_al;
    logic        is_load;
    logic        is_store;
    logic [31:0] st_data;
    logic [3:0]  st_be;

    logic [1:0]  lat_off;
    logic [5:0]  lat_op;
    logic [31:0] lat_pc;
    logic [5:0]  lat_wbr;
    logic        lat_load;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    logic        unused;

    assign unused  = ^x_instr[31:16];
    assign ea      = x_op1_val + {{16{x_instr[15]}}, x_instr[15:0]};
    assign ea_al   = {ea[31:2], 2'b00};
    assign m_stall = (state != IDLE);

    // Classify the opcode in execute as load, store or neither.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (x_opcode)
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load  = 1'b1;
            6'h28, 6'h29, 6'h2B:               is_store = 1'b1;
            default: ;
        endcase
    end

    // Replicate store data across lanes and pick big-endian byte enables.
    always_comb begin
        st_data = x_rt_val;
        st_be   = 4'b1111;
        case (x_opcode)
            6'h28: begin
                st_data = {4{x_rt_val[7:0]}};
                st_be   = 4'b0001 << ~ea[1:0];
            end
            6'h29: begin
                st_data = {2{x_rt_val[15:0]}};
                st_be   = ea[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase
    end

    // Pull the addressed lane out of the read word and extend it.
    always_comb begin
        ld_byte = dmem_readdata[{~lat_off, 3'b000} +: 8];
        ld_half = dmem_readdata[{~lat_off[1], 4'b0000} +: 16];
        ld_val  = dmem_readdata;
        case (lat_op)
            6'h20:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            6'h24:   ld_val = {24'd0, ld_byte};
            6'h21:   ld_val = {{16{ld_half[15]}}, ld_half};
            6'h25:   ld_val = {16'd0, ld_half};
            default: ld_val = dmem_readdata;
        endcase
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (x_valid && (is_load || is_store))
                    state_nx = REQ;
            end
            REQ: begin
                if (!dmem_waitrequest)
                    state_nx = lat_load ? RDWAIT : IDLE;
            end
            RDWAIT: begin
                if (dmem_readdatavalid)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Result, bus request and latched-instruction registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid      <= 1'b0;
            m_pc         <= '0;
            m_wbr        <= '0;
            m_res        <= '0;
            dmem_addr    <= '0;
            dmem_rd      <= 1'b0;
            dmem_wr      <= 1'b0;
            dmem_wrdata  <= '0;
            dmem_byteena <= '0;
            lat_off      <= '0;
            lat_op       <= '0;
            lat_pc       <= '0;
            lat_wbr      <= '0;
            lat_load     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (x_valid && (is_load || is_store)) begin
                        m_valid      <= 1'b0;
                        lat_off      <= ea[1:0];
                        lat_op       <= x_opcode;
                        lat_pc       <= x_pc;
                        lat_wbr      <= x_wbr;
                        lat_load     <= is_load;
                        dmem_addr    <= ea_al[ADDR_W-1:0];
                        dmem_rd      <= is_load;
                        dmem_wr      <= is_store;
                        dmem_wrdata  <= st_data;
                        dmem_byteena <= is_load ? 4'b1111 : st_be;
                    end else if (x_valid) begin
                        m_valid <= 1'b1;
                        m_pc    <= x_pc;
                        m_wbr   <= x_wbr;
                        m_res   <= x_res;
                    end else begin
                        m_valid <= 1'b0;
                    end
                end
                REQ: begin
                    m_valid <= 1'b0;
                    if (!dmem_waitrequest) begin
                        dmem_rd <= 1'b0;
                        dmem_wr <= 1'b0;
                        if (!lat_load) begin
                            m_valid <= 1'b1;
                            m_pc    <= lat_pc;
                            m_wbr   <= '0;
                        end
                    end
                end
                RDWAIT: begin
                    m_valid <= 1'b0;
                    if (dmem_readdatavalid) begin
                        m_valid <= 1'b1;
                        m_pc    <= lat_pc;
                        m_wbr   <= lat_wbr;
                        m_res   <= ld_val;
                    end
                end
                default: m_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_m.sv
// tb_stage_m: randomized scoreboard bench for stage_m.
// Driver pushes expected results and bus requests; slave and monitor pop and compare.
module tb_stage_m;

    logic        clock = 1'b0;
    logic        reset;
    logic        x_valid;
    logic [31:0] x_pc, x_instr, x_op1_val, x_rt_val, x_res;
    logic [5:0]  x_opcode, x_wbr;
    logic        m_stall, m_valid;
    logic [31:0] m_pc, m_res;
    logic [5:0]  m_wbr;
    logic [31:0] dmem_addr;
    logic        dmem_rd, dmem_wr;
    logic [31:0] dmem_wrdata;
    logic [3:0]  dmem_byteena;
    logic        dmem_waitrequest;
    logic [31:0] dmem_readdata;
    logic        dmem_readdatavalid;

    always #5 clock = ~clock;

    stage_m #(.ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .x_valid(x_valid), .x_pc(x_pc), .x_instr(x_instr),
        .x_opcode(x_opcode), .x_op1_val(x_op1_val),
        .x_rt_val(x_rt_val), .x_wbr(x_wbr), .x_res(x_res),
        .m_stall(m_stall), .m_valid(m_valid), .m_pc(m_pc),
        .m_wbr(m_wbr), .m_res(m_res),
        .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_wrdata(dmem_wrdata), .dmem_byteena(dmem_byteena),
        .dmem_waitrequest(dmem_waitrequest),
        .dmem_readdata(dmem_readdata),
        .dmem_readdatavalid(dmem_readdatavalid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  wbr;
        logic [31:0] res;
        bit          chk_res;
        int          stall;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        bit          rd;
        logic [3:0]  be;
        logic [31:0] wd;
        int          waits;
        int          lat;
    } bus_t;

    res_t        rq[$];
    bus_t        bq[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pc_ctr = 32'h100;
    int          stall_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdmem(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic bit is_mem_op(logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                          6'h28, 6'h29, 6'h2B};
    endfunction

    // Reference model: computes bus request, memory effect and result.
    task automatic model(logic [5:0] op, logic [31:0] pc, logic [31:0] instr,
                         logic [31:0] op1, logic [31:0] rt, logic [5:0] wbr,
                         logic [31:0] res, int waits, int lat);
        logic [31:0] off, ea, wa, word, v;
        int          k, h;
        res_t        r;
        bus_t        b;
        off = instr[15] ? (32'hFFFF0000 + instr[15:0]) : {16'd0, instr[15:0]};
        ea = op1 + off;
        wa = ea - (ea % 4);
        k = ea % 4;
        h = k / 2;
        r.pc = pc;
        r.wbr = wbr;
        r.res = res;
        r.chk_res = 1;
        r.stall = 0;
        if (op inside {6'h28, 6'h29, 6'h2B}) begin
            b.addr = wa; b.rd = 0; b.waits = waits; b.lat = 0;
            word = rdmem(wa);
            if (op == 6'h28) begin
                b.be = 4'(1 << (3 - k));
                b.wd = {4{rt[7:0]}};
            end else if (op == 6'h29) begin
                b.be = (h == 1) ? 4'b0011 : 4'b1100;
                b.wd = {2{rt[15:0]}};
            end else begin
                b.be = 4'b1111;
                b.wd = rt;
            end
            for (int i = 0; i < 4; i++)
                if (b.be[i]) word[8*i +: 8] = b.wd[8*i +: 8];
            mem[wa] = word;
            bq.push_back(b);
            r.wbr = 0;
            r.chk_res = 0;
            r.stall = waits + 1;
        end else if (is_mem_op(op)) begin
            b.addr = wa; b.rd = 1; b.be = 4'b1111; b.wd = 0;
            b.waits = waits; b.lat = lat;
            bq.push_back(b);
            word = rdmem(wa);
            if (op == 6'h20 || op == 6'h24) begin
                v = (word >> (8 * (3 - k))) % 256;
                if (op == 6'h20 && v >= 128) v = v + 32'hFFFFFF00;
            end else if (op == 6'h21 || op == 6'h25) begin
                v = (word >> (16 * (1 - h))) % 65536;
                if (op == 6'h21 && v >= 32768) v = v + 32'hFFFF0000;
            end else begin
                v = word;
            end
            r.res = v;
            r.stall = waits + 1 + lat;
        end
        rq.push_back(r);
    endtask

    task automatic issue(logic [5:0] op, logic [31:0] instr, logic [31:0] op1,
                         logic [31:0] rt, logic [5:0] wbr, logic [31:0] res,
                         int waits, int lat);
        int guard = 0;
        @(negedge clock);
        x_valid = 1; x_opcode = op; x_instr = instr; x_op1_val = op1;
        x_rt_val = rt; x_wbr = wbr; x_res = res; x_pc = pc_ctr;
        while (m_stall && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: m_stall stuck high, want low");
        end
        model(op, pc_ctr, instr, op1, rt, wbr, res, waits, lat);
        pc_ctr += 4;
        @(posedge clock);
    endtask

    task automatic bubble(int n);
        @(negedge clock);
        x_valid = 0;
        repeat (n - 1) @(negedge clock);
    endtask

    // Bus slave: checks each request against the model and answers it.
    initial begin : slave
        bus_t        cur;
        bit          active = 0;
        int          wait_left = 0;
        int          lat_cnt = 0;
        logic [31:0] pend = 0;
        dmem_waitrequest = 0;
        dmem_readdatavalid = 0;
        dmem_readdata = 0;
        forever begin
            @(negedge clock);
            dmem_readdatavalid = 0;
            dmem_readdata = $urandom;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    dmem_readdatavalid = 1;
                    dmem_readdata = rdmem(pend);
                end
            end else if ($urandom_range(0, 7) == 0) begin
                dmem_readdatavalid = 1;
            end
            if (reset) begin
                active = 0;
                dmem_waitrequest = 0;
            end else if (dmem_rd || dmem_wr) begin
                if (!active) begin
                    if (bq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL bus_unexpected: rd=%b wr=%b, want none",
                                 dmem_rd, dmem_wr);
                        cur.addr = dmem_addr; cur.rd = dmem_rd;
                        cur.be = dmem_byteena; cur.wd = dmem_wrdata;
                        cur.waits = 0; cur.lat = 1;
                    end else begin
                        cur = bq.pop_front();
                    end
                    active = 1;
                    wait_left = cur.waits;
                end
                chk("bus_rd", 32'(dmem_rd), 32'(cur.rd));
                chk("bus_wr", 32'(dmem_wr), 32'(!cur.rd));
                chk("bus_addr", dmem_addr, cur.addr);
                chk("bus_byteena", 32'(dmem_byteena), 32'(cur.be));
                if (!cur.rd) chk("bus_wrdata", dmem_wrdata, cur.wd);
                if (wait_left > 0) begin
                    dmem_waitrequest = 1;
                    wait_left--;
                end else begin
                    dmem_waitrequest = 0;
                    active = 0;
                    if (cur.rd) begin
                        lat_cnt = cur.lat;
                        pend = cur.addr;
                    end
                end
            end else begin
                dmem_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_cnt = 0;
                continue;
            end
            if (m_valid) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL result_unexpected: m_valid=1 pc=%h, want 0",
                             m_pc);
                end else begin
                    e = rq.pop_front();
                    chk("m_pc", m_pc, e.pc);
                    chk("m_wbr", 32'(m_wbr), 32'(e.wbr));
                    if (e.chk_res) chk("m_res", m_res, e.res);
                    chk("stall_cycles", stall_cnt, e.stall);
                end
                stall_cnt = 0;
            end
            if (m_stall) stall_cnt++;
        end
    end

    initial begin : driver
        logic [5:0]  op;
        logic [31:0] r32, base;
        logic [15:0] off;
        int          sel, guard;
        reset = 1; x_valid = 0; x_pc = 0; x_instr = 0; x_opcode = 0;
        x_op1_val = 0; x_rt_val = 0; x_wbr = 0; x_res = 0;
        repeat (2) @(negedge clock);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_stall", 32'(m_stall), 0);
        chk("rst_m_pc", m_pc, 0);
        chk("rst_m_res", m_res, 0);
        chk("rst_m_wbr", 32'(m_wbr), 0);
        chk("rst_dmem_rd", 32'(dmem_rd), 0);
        chk("rst_dmem_wr", 32'(dmem_wr), 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wrdata", dmem_wrdata, 0);
        chk("rst_dmem_byteena", 32'(dmem_byteena), 0);
        @(posedge clock); #2 reset = 0;

        issue(6'h00, 32'h0, 32'h0, 32'h0, 6'd5, 32'h12345678, 0, 1);
        mem[32'h0FFC] = 32'hCAFEBABE;
        issue(6'h23, 32'h0000FFFC, 32'h1000, 32'h0, 6'd7, 32'h0, 0, 1);
        mem[32'h2000] = 32'h11883344;
        issue(6'h20, 32'h1, 32'h2000, 32'h0, 6'd8, 32'h0, 0, 1);
        issue(6'h24, 32'h1, 32'h2000, 32'h0, 6'd9, 32'h0, 1, 2);
        issue(6'h25, 32'h2, 32'h2000, 32'h0, 6'd10, 32'h0, 0, 1);
        issue(6'h28, 32'h3, 32'h3000, 32'hAABBCCDD, 6'd11, 32'h0, 3, 1);
        issue(6'h23, 32'h0, 32'h3000, 32'h0, 6'd12, 32'h0, 0, 1);
        issue(6'h00, 32'h0, 32'h0, 32'h0, 6'd13, 32'h0BADF00D, 0, 1);
        bubble(3);

        issue(6'h23, 32'h0, 32'h2000, 32'h0, 6'd14, 32'h0, 0, 6);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_m_stall", 32'(m_stall), 0);
        chk("mid_rst_m_res", m_res, 0);
        chk("mid_rst_m_wbr", 32'(m_wbr), 0);
        chk("mid_rst_dmem_rd", 32'(dmem_rd), 0);
        chk("mid_rst_dmem_addr", dmem_addr, 0);
        rq.delete();
        bq.delete();
        x_valid = 0;
        @(posedge clock); #2 reset = 0;
        repeat (8) @(negedge clock);
        chk("post_rst_m_valid", 32'(m_valid), 0);
        chk("post_rst_m_stall", 32'(m_stall), 0);
        issue(6'h00, 32'h0, 32'h0, 32'h0, 6'd3, 32'h600DCAFE, 0, 1);

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 11);
            r32 = $urandom;
            off = 16'($urandom_range(0, 63)) - 16'd32;
            base = ($urandom_range(0, 7) == 0) ? $urandom
                                               : 32'h4000 + 32'($urandom_range(0, 15) * 4);
            case (sel)
                0: op = 6'h20; 1: op = 6'h21; 2: op = 6'h23; 3: op = 6'h24;
                4: op = 6'h25; 5: op = 6'h28; 6: op = 6'h29; 7: op = 6'h2B;
                8: op = 6'h22;
                9: op = 6'h2A;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (is_mem_op(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            if ($urandom_range(0, 9) == 0) bubble($urandom_range(1, 3));
            issue(op, {r32[31:16], off}, base, $urandom, 6'($urandom),
                  $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end
        bubble(2);

        guard = 0;
        while (rq.size() != 0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (rq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0",
                     rq.size());
        end
        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
